// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter. A request is latched into a work register,
// stepped one bit per cycle, and the result plus flags are registered on
// entry to DONE. Op 7 (LNK) computes a+2 directly with no shift steps.
module shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [3:0]  amt,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] s,
    output logic        C,
    output logic        N,
    output logic        Z,
    output logic        V
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [15:0] w;       // work register
    logic        c;       // carry register
    logic [2:0]  opr;     // latched op
    logic [3:0]  cnt;     // remaining 1-bit steps

    logic [15:0] w_nx;
    logic        c_nx;
    logic [3:0]  ld_cnt;
    logic [16:0] lnk_sum;
    logic [15:0] acc_s;
    logic        acc_c;
    logic        acc_v;

    // One 1-bit step of the work register for the latched op
    always_comb begin
        w_nx = w;
        c_nx = c;
        case (opr)
            3'd0: begin w_nx = {w[14:0], 1'b0}; c_nx = w[15]; end
            3'd1: begin w_nx = {1'b0, w[15:1]};  c_nx = w[0];  end
            3'd2: begin w_nx = {w[15], w[15:1]}; c_nx = w[0];  end
            3'd3: begin w_nx = {w[0], w[15:1]};  c_nx = w[0];  end
            3'd4: begin w_nx = {c, w[15:1]};     c_nx = w[0];  end
            default: ;
        endcase
    end

    // Step count to load on accept, and the result used when no steps are needed
    always_comb begin
        lnk_sum = {1'b0, a} + 17'd2;
        acc_s   = a;
        acc_c   = cin;
        acc_v   = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: ld_cnt = amt;
            3'd4:                   ld_cnt = 4'd1;
            default:                ld_cnt = 4'd0;
        endcase
        if (op == 3'd5 || op == 3'd6) begin
            acc_s = 16'd0;
        end else if (op == 3'd7) begin
            acc_s = lnk_sum[15:0];
            acc_c = lnk_sum[16];
            acc_v = ~a[15] & lnk_sum[15];
        end
    end

    // Control FSM with registered busy/done, result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w     <= 16'd0;
            c     <= 1'b0;
            opr   <= 3'd0;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= 16'd0;
            C     <= 1'b0;
            N     <= 1'b0;
            Z     <= 1'b1;
            V     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w    <= a;
                        c    <= cin;
                        opr  <= op;
                        cnt  <= ld_cnt;
                        busy <= 1'b1;
                        if (ld_cnt != 4'd0) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            s     <= acc_s;
                            C     <= acc_c;
                            N     <= acc_s[15];
                            Z     <= (acc_s == 16'd0);
                            V     <= acc_v;
                        end
                    end
                end
                SHIFT: begin
                    w   <= w_nx;
                    c   <= c_nx;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                        s     <= w_nx;
                        C     <= c_nx;
                        N     <= w_nx[15];
                        Z     <= (w_nx == 16'd0);
                        V     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed vector table, hand-written corner sequences and
// random ops checked against an arithmetic reference model.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [3:0]  amt;
    logic        cin;
    logic        busy, done;
    logic [15:0] s;
    logic        C, N, Z, V;

    int errors = 0;
    int checks = 0;

    shift_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .amt(amt), .cin(cin),
        .busy(busy), .done(done), .s(s), .C(C), .N(N), .Z(Z), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [3:0]  amt;
        logic        cin;
        logic [15:0] es;
        logic        ec, en, ez, ev;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: whole-operation result computed with plain shifts/arithmetic
    function automatic void model(input logic [2:0] o, input logic [15:0] av, input logic [3:0] am,
                                  input logic ci, output logic [15:0] es, output logic ec,
                                  output logic ev, output int elat);
        int k;
        logic [16:0] sum;
        es = 16'd0; ec = ci; ev = 1'b0;
        k = (o <= 3) ? int'(am) : ((o == 4) ? 1 : 0);
        elat = k + 1;
        case (o)
            3'd0: begin es = av << k; if (k != 0) ec = av[16-k]; end
            3'd1: begin es = av >> k; if (k != 0) ec = av[k-1]; end
            3'd2: begin es = 16'($signed(av) >>> k); if (k != 0) ec = av[k-1]; end
            3'd3: begin es = (av >> k) | (av << (16 - k)); if (k != 0) ec = av[k-1]; end
            3'd4: begin es = {ci, av[15:1]}; ec = av[0]; end
            3'd7: begin sum = {1'b0, av} + 17'd2; es = sum[15:0]; ec = sum[16]; ev = ~av[15] & es[15]; end
            default: begin es = 16'd0; ec = ci; end
        endcase
    endfunction

    // Issue one op from IDLE, wait for done (bounded), return latency and busy count
    task automatic run_op(input logic [2:0] o, input logic [15:0] av, input logic [3:0] am,
                          input logic ci, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; a = av; amt = am; cin = ci;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " s"}, 32'(s), 32'h0);
        chk({tag, " flags CNZV"}, 32'({C, N, Z, V}), 32'b0010);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
    endtask

    initial begin
        int lat, bcnt, elat, seen;
        logic [15:0] es;
        logic ec, ev;
        logic [2:0] ro;
        logic [15:0] ra;
        logic [3:0] ram;
        logic rc;

        vecs[0] = '{3'd0, 16'h8001, 4'd1,  1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[1] = '{3'd2, 16'h8000, 4'd15, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[2] = '{3'd4, 16'h0001, 4'd9,  1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 2};
        vecs[3] = '{3'd3, 16'h0001, 4'd4,  1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vecs[4] = '{3'd7, 16'h7FFF, 4'd3,  1'b0, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[5] = '{3'd7, 16'hFFFE, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{3'd1, 16'h1234, 4'd0,  1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[7] = '{3'd5, 16'hABCD, 4'd7,  1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[8] = '{3'd0, 16'h0001, 4'd15, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[9] = '{3'd1, 16'h8000, 4'd15, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16};

        rst = 1'b1; start = 1'b0; op = 3'd0; a = 16'd0; amt = 4'd0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].amt, vecs[i].cin, lat, bcnt);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d s", i), 32'(s), 32'(vecs[i].es));
            chk($sformatf("vec%0d CNZV", i), 32'({C, N, Z, V}),
                32'({vecs[i].ec, vecs[i].en, vecs[i].ez, vecs[i].ev}));
            chk($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat));
        end
        @(negedge clk);
        chk("idle after done busy", 32'(busy), 32'h0);
        chk("idle after done done", 32'(done), 32'h0);

        // Abort mid-SHIFT: LSR 0x00F0 amt=8, start re-pulsed, rst at cycle 5
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 16'h00F0; amt = 4'd8; cin = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 3'd7; a = 16'h0000;
        @(negedge clk); start = 1'b0;
        chk("abort busy mid-shift", 32'(busy), 32'h1);
        chk("abort s held mid-shift", 32'(s), 32'h0001);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_reset_vals("abort");
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort no done pulse", 32'(seen), 32'h0);
        chk("abort busy stays low", 32'(busy), 32'h0);

        // start together with rst is dropped
        @(negedge clk); rst = 1'b1; start = 1'b1; op = 3'd7; a = 16'h0010;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start under rst busy", 32'(busy), 32'h0);
        chk("start under rst s", 32'(s), 32'h0);

        // start held high: LSR amt=0 accepted every other cycle
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 16'h1234; amt = 4'd0; cin = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b done[%0d]", i), 32'(done), 32'((i % 2) == 0));
            chk($sformatf("b2b busy[%0d]", i), 32'(busy), 32'((i % 2) == 0));
        end
        chk("b2b s", 32'(s), 32'h1234);
        chk("b2b C", 32'(C), 32'h1);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            ram = 4'($urandom);
            rc = 1'($urandom);
            model(ro, ra, ram, rc, es, ec, ev, elat);
            run_op(ro, ra, ram, rc, lat, bcnt);
            chk($sformatf("rnd%0d op%0d latency", i, ro), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d op%0d a=%h amt=%0d s", i, ro, ra, ram), 32'(s), 32'(es));
            chk($sformatf("rnd%0d op%0d CNZV", i, ro), 32'({C, N, Z, V}),
                32'({ec, es[15], es == 16'd0, ev}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
